// File: rtl/pp_wr_arbiter.sv
// Round-robin burst write arbiter feeding a ping-pong buffer write port.
// Optional stall statistics counter enabled by macro PP_WR_ARB_STATS_EN.
module pp_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                     wclk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     full_i,
    output logic                     wen_o,
    output logic [WIDTH-1:0]         data_o,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic                     bank_o,
    output logic [15:0]              stall_cnt_o
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SUM_W = PTR_W + 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);
    localparam logic [SUM_W-1:0] NUM_REQ_S = SUM_W'(NUM_REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   gnt_idx, gnt_idx_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
    logic               bank_nxt;

    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    logic [SUM_W-1:0]   cand;
    logic               gnt_valid;
    logic               accept;
    logic [PTR_W-1:0]   gnt_idx_inc;

    logic [WIDTH-1:0]   req_beat [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_beat
        assign req_beat[i] = req_data[i*WIDTH +: WIDTH];
    end

    assign gnt_valid   = req_valid[gnt_idx];
    assign accept      = (state == BURST) && gnt_valid && !full_i && !reset;
    assign gnt_idx_inc = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);

    // Beat path is combinational so a beat lands in the buffer the same cycle.
    assign wen_o     = accept;
    assign data_o    = accept ? req_beat[gnt_idx] : '0;
    assign req_ready = ((state == BURST) && !full_i && !reset) ? gnt_o : '0;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = SUM_W'(rr_ptr) + SUM_W'(k);
            if (cand >= NUM_REQ_S) begin
                cand = cand - NUM_REQ_S;
            end
            if (!pick_found && req_valid[PTR_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'(cand);
            end
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        state_nxt    = state;
        gnt_idx_nxt  = gnt_idx;
        gnt_nxt      = gnt_o;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        bank_nxt     = bank_o ^ accept;

        case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (pick_found) begin
                    state_nxt    = BURST;
                    gnt_idx_nxt  = pick_idx;
                    gnt_nxt      = NUM_REQ'(1) << pick_idx;
                    beat_cnt_nxt = '0;
                end
            end
            BURST: begin
                if (!gnt_valid || (!full_i && beat_cnt == LAST_BEAT)) begin
                    state_nxt  = IDLE;
                    gnt_nxt    = '0;
                    rr_ptr_nxt = gnt_idx_inc;
                end else if (!full_i) begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge wclk) begin
        if (reset) begin
            state    <= IDLE;
            gnt_idx  <= '0;
            gnt_o    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            bank_o   <= 1'b0;
        end else begin
            state    <= state_nxt;
            gnt_idx  <= gnt_idx_nxt;
            gnt_o    <= gnt_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
            bank_o   <= bank_nxt;
        end
    end

`ifdef PP_WR_ARB_STATS_EN
    logic [15:0] stall_cnt;

    // Cycles where the owner has a beat ready but the buffer is full.
    always_ff @(posedge wclk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if ((state == BURST) && gnt_valid && full_i && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = 16'h0;
`endif

endmodule

// File: doc/pp_wr_arbiter.md
PP_WR_ARBITER -- requirements
Module: pp_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter WIDTH, default 8, data width per beat.
REQ-003 Parameter BURST_LEN, default 4, maximum beats per grant (1..16).
REQ-004 wclk  in  1  single clock for the block; one clock, reset is synchronous and active-high.
REQ-005 reset  in  1  synchronous active-high reset, sampled on posedge wclk.
REQ-006 req_valid  in  NUM_REQ  per-requester beat valid.
REQ-007 req_data  in  NUM_REQ*WIDTH  per-requester beat data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_ready  out  NUM_REQ  per-requester beat accept.
REQ-009 full_i  in  1  full flag from the downstream ping-pong buffer write side.
REQ-010 wen_o  out  1  write enable to the downstream buffer.
REQ-011 data_o  out  WIDTH  write data to the downstream buffer.
REQ-012 gnt_o  out  NUM_REQ  one-hot current grant, zero when idle.
REQ-013 bank_o  out  1  shadow bank pointer: buffer bank that receives the next write.
REQ-014 stall_cnt_o  out  16  count of cycles with the granted requester valid but blocked by full_i.

Function
REQ-015 The block SHALL have two states: IDLE and BURST, encoded in a registered state variable.
REQ-016 In IDLE with any req_valid bit set, the block SHALL grant the first valid requester at or after rr_ptr (searching upward, wrapping), load gnt_o and enter BURST on the next edge.
REQ-017 In IDLE with no req_valid set, the block SHALL stay in IDLE with gnt_o = 0.
REQ-018 A beat SHALL be accepted in a cycle iff state = BURST, the granted requester's req_valid = 1, and full_i = 0.
REQ-019 req_ready[i] SHALL be 1 iff state = BURST, gnt_o[i] = 1 and full_i = 0 (combinational).
REQ-020 wen_o SHALL equal the accept condition in the same cycle (zero latency); data_o SHALL be the granted requester's req_data, or 0 when wen_o = 0.
REQ-021 A 4-bit beat counter SHALL clear on entry to BURST and increment on each accepted beat.
REQ-022 The burst SHALL end (return to IDLE, gnt_o cleared next cycle) on the edge after the beat accepted with counter = BURST_LEN-1, or after a BURST cycle in which the granted req_valid = 0.
REQ-023 On burst end, rr_ptr SHALL load (granted index + 1) mod NUM_REQ; one idle cycle always separates bursts.
REQ-024 full_i = 1 in BURST SHALL hold state, grant and counter unchanged (no timeout); stall_cnt_o SHALL increment when granted req_valid = 1, saturating at 16'hFFFF.
REQ-025 bank_o SHALL toggle on every accepted beat.
REQ-026 gnt_o SHALL be one-hot or zero at all times; wen_o SHALL never assert while full_i = 1.

Reset
REQ-027 reset = 1 SHALL force on the next edge: state IDLE, gnt_o = 0, rr_ptr = 0, beat counter = 0, bank_o = 0, stall_cnt_o = 0.
REQ-028 wen_o and req_ready SHALL be 0 in any cycle where reset = 1, including a reset asserted mid-burst; the partial burst is abandoned and not resumed.

Configuration
REQ-029 Macro PP_WR_ARB_STATS_EN defined: stall_cnt_o SHALL behave per REQ-024.
REQ-030 PP_WR_ARB_STATS_EN undefined: stall_cnt_o SHALL be constant 0 and its counter SHALL not be instantiated; all other behaviour is identical.

Verification
REQ-031 Reset, then req_valid = 4'b0001 with data 8'hA0..A5 held, full_i = 0 -> req 0 granted, wen_o pulses 4 beats A0..A3, IDLE one cycle, regrant, beats A4, A5.
REQ-032 req_valid = 4'b1111 continuously, BURST_LEN = 4 -> grant order 0,1,2,3,0; each burst exactly 4 beats; one idle cycle between bursts.
REQ-033 Req 2 granted, full_i = 1 for 5 cycles after beat 2 -> wen_o = 0, req_ready = 0, gnt_o = 4'b0100 held, stall_cnt_o += 5 (0 with macro off), burst then completes beats 3..4.
REQ-034 Req 1 granted, req_valid[1] drops after 2 beats -> burst ends, next grant searches from index 2, bank_o toggled twice.
REQ-035 reset = 1 in second beat of a burst -> wen_o = 0 same cycle; next cycle gnt_o = 0, bank_o = 0, rr_ptr = 0; first grant after reset goes to lowest valid index.
